// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the I/D-cache memory-port arbiter.
package cache_arb_pkg;

  localparam int ARB_ADDR_W = 28;
  localparam int ARB_DATA_W = 128;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_GNT_I = 2'd1;
  localparam arb_state_t ST_GNT_D = 2'd2;
  localparam arb_state_t ST_DONE  = 2'd3;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between the masked I and D requests.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise the D-cache wins ties.
module arb_pick
  import cache_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_owner,
`endif
  output logic gnt_valid,
  output logic gnt_owner
);

  always_comb begin
    gnt_valid = req_i | req_d;
    gnt_owner = OWN_D;
    if (req_i && req_d) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt_owner = (last_owner == OWN_D) ? OWN_I : OWN_D;
`else
      gnt_owner = OWN_D;
`endif
    end else if (req_i) begin
      gnt_owner = OWN_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the off-chip memory port between the I-cache and D-cache, one grant at a time.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie-breaking (default fixed D priority).
//
// state  | meaning
// IDLE   | evaluate masked requests, register winner into mem_*
// GNT_I  | I-cache owns the port, wait for mem_ready
// GNT_D  | D-cache owns the port, wait for mem_ready
// DONE   | owner's ready pulse is high, rdata valid
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t state;
  logic       owner;
  logic       mask_v;
  logic       mask_owner;
  logic       req_i;
  logic       req_d;
  logic       gnt_valid;
  logic       gnt_owner;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_owner;
`endif

  // The served requester is ignored for one IDLE cycle so its late de-assertion
  // cannot win a second grant.
  assign req_i = ic_read & ~(mask_v & (mask_owner == OWN_I));
  assign req_d = (dc_read | dc_write) & ~(mask_v & (mask_owner == OWN_D));

  arb_pick u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_D;
      mask_v     <= 1'b0;
      mask_owner <= OWN_D;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
      ic_ready   <= 1'b0;
      dc_ready   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= OWN_D;
`endif
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          mask_v <= 1'b0;
          if (gnt_valid) begin
            owner <= gnt_owner;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= gnt_owner;
`endif
            if (gnt_owner == OWN_D) begin
              state     <= ST_GNT_D;
              mem_addr  <= dc_addr;
              mem_wdata <= dc_wdata;
              // a write-back wins over a simultaneous (illegal) read
              mem_write <= dc_write;
              mem_read  <= ~dc_write;
            end else begin
              state     <= ST_GNT_I;
              mem_addr  <= ic_addr;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
            end
          end
        end
        ST_GNT_I, ST_GNT_D: begin
          if (mem_ready) begin
            if (mem_read) begin
              if (owner == OWN_D) dc_rdata <= mem_rdata;
              else                ic_rdata <= mem_rdata;
            end
            if (owner == OWN_D) dc_ready <= 1'b1;
            else                ic_ready <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          mask_v     <= 1'b1;
          mask_owner <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_dc_rw_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(dc_read && dc_write));
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: transaction-level reference model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_cache_mem_arbiter;

  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_read = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [DW-1:0] ic_rdata;
  logic          ic_ready;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [DW-1:0] dc_wdata = '0;
  logic [DW-1:0] dc_rdata;
  logic          dc_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  cache_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ic_read   (ic_read),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_ready  (ic_ready),
    .dc_read   (dc_read),
    .dc_write  (dc_write),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_ready  (dc_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
    return {4{4'hC, a}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // memory model: answers LAT cycles after the strobe first appears
  int   mcnt = 0;
  bit   spur = 1'b0;
  logic rst_s;
  always @(posedge clk) begin
    rst_s = rst_n;
    #1;
    mem_ready = 1'b0;
    if (!rst_s) begin
      mcnt = 0;
    end else if (spur) begin
      spur      = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
    end else if (mem_read || mem_write) begin
      mcnt++;
      if (mcnt == LAT + 1) begin
        mcnt      = 0;
        mem_ready = 1'b1;
        mem_rdata = line_of(mem_addr);
      end
    end
  end

  // reference model: one outstanding transaction, a completion cycle,
  // then one IDLE cycle in which the previous owner is ignored
  logic          e_ic_ready = 1'b0, e_dc_ready = 1'b0, e_rd = 1'b0, e_wr = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_ic_rdata = '0, e_dc_rdata = '0;
  bit            busy = 0, done = 0, mask_v = 0, mask_d = 0, own_d = 0;
  bit            wi, wd, pick_d;
`ifdef ARB_ROUND_ROBIN_EN
  bit            last_d = 1;
`endif

  always @(posedge clk) begin
    if (!rst_n) begin
      e_ic_ready = 0; e_dc_ready = 0; e_rd = 0; e_wr = 0;
      e_addr = '0; e_wdata = '0; e_ic_rdata = '0; e_dc_rdata = '0;
      busy = 0; done = 0; mask_v = 0; mask_d = 0; own_d = 0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d = 1;
`endif
    end else begin
      e_ic_ready = 0;
      e_dc_ready = 0;
      if (busy) begin
        if (mem_ready) begin
          if (e_rd) begin
            if (own_d) e_dc_rdata = mem_rdata;
            else       e_ic_rdata = mem_rdata;
          end
          if (own_d) e_dc_ready = 1;
          else       e_ic_ready = 1;
          e_rd = 0; e_wr = 0; busy = 0; done = 1;
        end
      end else if (done) begin
        done = 0; mask_v = 1; mask_d = own_d;
      end else begin
        wi = ic_read && !(mask_v && !mask_d);
        wd = (dc_read || dc_write) && !(mask_v && mask_d);
        mask_v = 0;
        if (wi || wd) begin
          if (wi && wd) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_d = !last_d;
`else
            pick_d = 1;
`endif
          end else begin
            pick_d = wd;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_d = pick_d;
`endif
          own_d = pick_d;
          busy  = 1;
          if (pick_d) begin
            e_addr = dc_addr; e_wdata = dc_wdata; e_wr = dc_write; e_rd = !dc_write;
          end else begin
            e_addr = ic_addr; e_rd = 1; e_wr = 0;
          end
        end
      end
    end
  end

  bit chk_en = 0;
  int order[$];
  int n_ic_p = 0, n_dc_p = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ic_ready",  DW'(ic_ready),  DW'(e_ic_ready));
      check("dc_ready",  DW'(dc_ready),  DW'(e_dc_ready));
      check("mem_read",  DW'(mem_read),  DW'(e_rd));
      check("mem_write", DW'(mem_write), DW'(e_wr));
      check("ic_rdata",  ic_rdata, e_ic_rdata);
      check("dc_rdata",  dc_rdata, e_dc_rdata);
      if (e_rd || e_wr) check("mem_addr", DW'(mem_addr), DW'(e_addr));
      if (e_wr)         check("mem_wdata", mem_wdata, e_wdata);
      if (ic_ready) begin order.push_back(0); n_ic_p++; end
      if (dc_ready) begin order.push_back(1); n_dc_p++; end
    end
  end

  task automatic wait_ready(input bit want_d, input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 40; k++) begin
      if (want_d ? dc_ready : ic_ready) begin
        ok = 1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: ready not seen within 40 cycles", name);
    end
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: simulation still running at 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int snap;
    int exp_order[3];

    rst_n = 1'b0;
    step();
    chk_en = 1;
    step();
    step();
    rst_n = 1'b1;
    check("rst mem_read", DW'(mem_read), DW'(0));
    check("rst mem_addr", DW'(mem_addr), DW'(0));
    check("rst ic_rdata", ic_rdata, '0);

    // single I-cache read
    ic_addr = 28'h0000010;
    ic_read = 1'b1;
    step();
    check("t1 mem_read", DW'(mem_read), DW'(1));
    check("t1 mem_addr", DW'(mem_addr), DW'(28'h0000010));
    k = 0;
    while (!ic_ready && k < 20) begin
      step();
      k++;
    end
    ic_read = 1'b0;
    check("t1 ready latency", DW'(k), DW'(6));
    check("t1 ic_rdata", ic_rdata, 128'hC0000010_C0000010_C0000010_C0000010);
    step();
    check("t1 ready width", DW'(ic_ready), DW'(0));

    // spurious mem_ready while idle
    snap = n_ic_p + n_dc_p;
    spur = 1'b1;
    repeat (4) step();
    check("spur pulses", DW'(n_ic_p + n_dc_p - snap), DW'(0));
    check("spur ic_rdata", ic_rdata, 128'hC0000010_C0000010_C0000010_C0000010);

    // D-cache write-back
    dc_addr  = 28'h0ABCDEF;
    dc_wdata = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    dc_write = 1'b1;
    step();
    check("t2 mem_write", DW'(mem_write), DW'(1));
    check("t2 mem_read", DW'(mem_read), DW'(0));
    check("t2 mem_addr", DW'(mem_addr), DW'(28'h0ABCDEF));
    check("t2 mem_wdata", mem_wdata, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
    wait_ready(1, "t2 dc_ready");
    dc_write = 1'b0;
    check("t2 dc_rdata kept", dc_rdata, '0);
    repeat (2) step();

    // served requester holds one extra cycle; the other one is granted instead
    ic_addr = 28'h0000200;
    ic_read = 1'b1;
    step();
    dc_addr = 28'h0000300;
    dc_read = 1'b1;
    snap = n_ic_p;
    wait_ready(0, "t3 ic_ready");
    step();
    step();
    ic_read = 1'b0;
    check("t3 d granted", DW'({mem_read, mem_addr}), DW'({1'b1, 28'h0000300}));
    wait_ready(1, "t3 dc_ready");
    dc_read = 1'b0;
    check("t3 dc_rdata", dc_rdata, 128'hC0000300_C0000300_C0000300_C0000300);
    repeat (12) step();
    check("t3 single i grant", DW'(n_ic_p - snap), DW'(1));

    // simultaneous requests from reset, I held, D dropped after its service
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    order.delete();
    ic_addr = 28'h0000400;
    dc_addr = 28'h0000500;
    ic_read = 1'b1;
    dc_read = 1'b1;
    for (int j = 0; j < 80 && order.size() < 3; j++) begin
      step();
      if (dc_ready) dc_read = 1'b0;
    end
    ic_read = 1'b0;
    dc_read = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{1, 0, 0};
`endif
    check("t4 served count", DW'(order.size() >= 3), DW'(1));
    if (order.size() >= 3) begin
      for (int j = 0; j < 3; j++) check($sformatf("t4 order[%0d]", j), DW'(order[j]), DW'(exp_order[j]));
    end
    repeat (15) step();

    // reset in the middle of a D-cache grant
    dc_addr = 28'h0000600;
    dc_read = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    dc_read = 1'b0;
    step();
    rst_n = 1'b1;
    check("t5 mem_read", DW'(mem_read), DW'(0));
    check("t5 mem_addr", DW'(mem_addr), DW'(0));
    check("t5 dc_ready", DW'(dc_ready), DW'(0));
    check("t5 ic_rdata", ic_rdata, '0);
    snap = n_dc_p;
    spur = 1'b1;
    repeat (8) step();
    check("t5 no dc_ready", DW'(n_dc_p - snap), DW'(0));
    check("t5 dc_rdata", dc_rdata, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
